// File: rtl/valid_in_pulse_gen.sv
// valid_in_pulse_gen: multi-channel push-button front end.
// Each channel debounces a raw level input and turns every qualified press
// into a single-cycle valid strobe. While the input stays held, a channel can
// optionally auto-repeat the strobe: first after RPT_DELAY cycles, then
// every RPT_PERIOD cycles. Channels are fully independent, so coincident
// presses produce coincident strobes.
module valid_in_pulse_gen #(
    parameter int CH_NUM     = 4,
    parameter int DEB_CYCLES = 3,
    parameter int RPT_DELAY  = 16,
    parameter int RPT_PERIOD = 8,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CH_NUM-1:0]     btn,
    input  logic [CH_NUM-1:0]     repeat_en,
    output logic [CH_NUM-1:0]     out,
    output logic                  any_out,
    output logic [2*CH_NUM-1:0]   state_test
);

    // Channel states; the numeric values are visible on state_test.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2,
        QUAL  = 2'd3
    } chan_state_t;

    // Terminal counter values. Debounce counts high samples already seen,
    // so the press qualifies when the counter reads DEB_CYCLES-1 and the
    // current sample is high. The repeat counters stop two short of the
    // spacing because one cycle is spent in PULSE and one entering HOLD.
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(RPT_DELAY - 2);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(RPT_PERIOD - 2);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = '0;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        chan_state_t      state;
        chan_state_t      state_next;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic             rpt_flag;
        logic             rpt_flag_next;
        logic [CNT_W-1:0] limit_last;

        // State, counter and repeat flag registers; reset clears everything at once.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state    <= IDLE;
                cnt      <= CNT_ZERO;
                rpt_flag <= 1'b0;
            end else begin
                state    <= state_next;
                cnt      <= cnt_next;
                rpt_flag <= rpt_flag_next;
            end
        end

        // Next-state logic: debounce in QUAL, one-cycle strobe in PULSE, repeat timing in HOLD.
        always_comb begin
            state_next    = state;
            cnt_next      = cnt;
            rpt_flag_next = rpt_flag;
            limit_last    = rpt_flag ? PERIOD_LAST : DELAY_LAST;

            case (state)
                IDLE: begin
                    if (btn[i]) begin
                        if (DEB_CYCLES == 1) begin
                            state_next = PULSE;
                        end else begin
                            state_next = QUAL;
                            cnt_next   = CNT_ONE;
                        end
                    end else begin
                        rpt_flag_next = 1'b0;
                    end
                end

                QUAL: begin
                    if (!btn[i]) begin
                        state_next = IDLE;
                        cnt_next   = CNT_ZERO;
                    end else if (cnt == DEB_LAST) begin
                        state_next = PULSE;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end

                PULSE: begin
                    state_next = HOLD;
                    cnt_next   = CNT_ZERO;
                end

                HOLD: begin
                    if (!btn[i]) begin
                        state_next    = IDLE;
                        cnt_next      = CNT_ZERO;
                        rpt_flag_next = 1'b0;
                    end else if (!repeat_en[i]) begin
                        cnt_next = CNT_ZERO;
                    end else if (cnt == limit_last) begin
                        state_next    = PULSE;
                        rpt_flag_next = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end

                default: begin
                    state_next    = IDLE;
                    cnt_next      = CNT_ZERO;
                    rpt_flag_next = 1'b0;
                end
            endcase
        end

        assign out[i]              = (state == PULSE);
        assign state_test[2*i +: 2] = state;
    end

    assign any_out = |out;

endmodule
